// File: rtl/adder_mpseq_pkg.sv
// Shared types and constants for the word-serial multi-precision adder.
package adder_mpseq_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned HALF_W = WORD_W / 2;

    // FSM state encoding
    localparam int unsigned ST_W = 2;
    typedef logic [ST_W-1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;

    // One word of operand payload
    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
    } operand_t;

    // One word of adder result
    typedef struct packed {
        logic              cout;
        logic [WORD_W-1:0] sum;
    } word_res_t;

    // Word counter width; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_16b_csel_core.sv
// Combinational 16-bit carry-select adder: the high byte is precomputed
// for both carry values and picked by the low-byte carry.
module adder_16b_csel_core
    import adder_mpseq_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    logic [HALF_W:0] lo;
    logic [HALF_W:0] hi0;
    logic [HALF_W:0] hi1;

    // Low half ripple plus both speculative high halves
    always_comb begin
        lo  = (HALF_W+1)'(a[HALF_W-1:0]) + (HALF_W+1)'(b[HALF_W-1:0])
            + (HALF_W+1)'(cin);
        hi0 = (HALF_W+1)'(a[WORD_W-1:HALF_W]) + (HALF_W+1)'(b[WORD_W-1:HALF_W]);
        hi1 = (HALF_W+1)'(a[WORD_W-1:HALF_W]) + (HALF_W+1)'(b[WORD_W-1:HALF_W])
            + (HALF_W+1)'(1'b1);
    end

    // Select the high half with the low-half carry
    always_comb begin
        sum[HALF_W-1:0] = lo[HALF_W-1:0];
        if (lo[HALF_W]) begin
            sum[WORD_W-1:HALF_W] = hi1[HALF_W-1:0];
            cout                 = hi1[HALF_W];
        end else begin
            sum[WORD_W-1:HALF_W] = hi0[HALF_W-1:0];
            cout                 = hi0[HALF_W];
        end
    end

endmodule

// File: rtl/adder_16b_csel_mpseq.sv
// Word-serial multi-precision add sequencer: chains carry across NWORDS
// words (LS word first) with a 1-deep registered output stage.
module adder_16b_csel_mpseq
    import adder_mpseq_pkg::*;
#(
    parameter int unsigned NWORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cin,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_last,
    output logic              done,
    output logic              cout
);

    localparam int unsigned CW = cnt_width(NWORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

    state_t            state, state_d;
    logic              carry, carry_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              busy_d;
    logic              out_valid_d;
    logic [WORD_W-1:0] out_sum_d;
    logic              out_last_d;
    logic              done_d;
    logic              cout_d;

    operand_t          opnd;
    word_res_t         res;
    logic              accept;
    logic              drain;
    logic              last_word;

    assign opnd = '{a: in_a, b: in_b};

    adder_16b_csel_core u_core (
        .a    (opnd.a),
        .b    (opnd.b),
        .cin  (carry),
        .sum  (res.sum),
        .cout (res.cout)
    );

    // Input is taken only in RUN when the output slot is free or draining;
    // abort masks it so upstream never sees a handshake that is dropped.
    assign in_ready  = (state == ST_RUN) && !abort && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign last_word = (cnt == LAST_IDX);

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        carry_d     = carry;
        cnt_d       = cnt;
        out_valid_d = out_valid;
        out_sum_d   = out_sum;
        out_last_d  = out_last;
        done_d      = 1'b0;
        cout_d      = cout;

        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        carry_d = cin;
                        cnt_d   = '0;
                        cout_d  = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (drain) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                    if (accept) begin
                        out_sum_d   = res.sum;
                        out_valid_d = 1'b1;
                        out_last_d  = last_word;
                        carry_d     = res.cout;
                        if (last_word) begin
                            state_d = ST_FLUSH;
                        end else begin
                            cnt_d = cnt + CW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (drain) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        cout_d      = carry;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            carry     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            cout      <= 1'b0;
        end else begin
            state     <= state_d;
            carry     <= carry_d;
            cnt       <= cnt_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
            out_sum   <= out_sum_d;
            out_last  <= out_last_d;
            done      <= done_d;
            cout      <= cout_d;
        end
    end

endmodule

// File: tb/tb_adder_16b_csel_mpseq.sv
// Self-checking bench for adder_16b_csel_mpseq (NWORDS=4 and NWORDS=1).
module tb_adder_16b_csel_mpseq;

    logic        clk;
    logic        rst_n;

    // NWORDS=4 instance
    logic        start, abort, cin, busy;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, done, cout;
    logic [15:0] in_a, in_b, out_sum;

    // NWORDS=1 instance
    logic        s1_start, s1_abort, s1_cin, s1_busy;
    logic        s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
    logic        s1_out_last, s1_done, s1_cout;
    logic [15:0] s1_in_a, s1_in_b, s1_out_sum;

    int checks;
    int errors;

    typedef struct {
        logic        cin;
        logic [15:0] a [4];
        logic [15:0] b [4];
        logic [15:0] s [4];
        logic        cout;
    } vec_t;

    typedef struct packed {
        logic [15:0] sum;
        logic        last;
    } exp_t;

    vec_t tab [4];
    exp_t sb_q [$];

    adder_16b_csel_mpseq #(.NWORDS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cin       (cin),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .done      (done),
        .cout      (cout)
    );

    adder_16b_csel_mpseq #(.NWORDS(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s1_start),
        .abort     (s1_abort),
        .cin       (s1_cin),
        .busy      (s1_busy),
        .in_valid  (s1_in_valid),
        .in_ready  (s1_in_ready),
        .in_a      (s1_in_a),
        .in_b      (s1_in_b),
        .out_valid (s1_out_valid),
        .out_ready (s1_out_ready),
        .out_sum   (s1_out_sum),
        .out_last  (s1_out_last),
        .done      (s1_done),
        .cout      (s1_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Run one full 4-word operation from table entry v with an optional
    // output stall on the first word and an optional start pulse mid-run.
    task automatic run_op(input int v, input int stall, input bit mid_start);
        int   sent = 0;
        int   got = 0;
        int   cyc = 0;
        int   stall_left = stall;
        exp_t e;
        cin   = tab[v].cin;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("cout_cleared_on_start", cout, 0);
        while (got < 4 && cyc < 200) begin
            in_valid  = (sent < 4);
            in_a      = (sent < 4) ? tab[v].a[sent] : 16'h0;
            in_b      = (sent < 4) ? tab[v].b[sent] : 16'h0;
            start     = mid_start && (sent == 2);
            out_ready = !(out_valid && stall_left > 0);
            #1;
            if (out_valid && stall_left > 0) begin
                stall_left--;
                chk("stall_in_ready", in_ready, 0);
                if (sb_q.size() > 0) chk("stall_out_sum_hold", out_sum, sb_q[0].sum);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_sum", out_sum, e.sum);
                    chk("out_last", out_last, e.last);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back('{sum: tab[v].s[sent], last: (sent == 3)});
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk("op_timeout", (cyc < 200), 1);
        chk("words_sent", sent, 4);
        chk("words_got", got, 4);
        chk("done_pulse", done, 1);
        chk("cout_final", cout, tab[v].cout);
        chk("busy_after_done", busy, 0);
        chk("out_valid_after_done", out_valid, 0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("cout_held", cout, tab[v].cout);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 0; abort = 0; cin = 0; in_valid = 0; out_ready = 1; in_a = 0; in_b = 0;
        s1_start = 0; s1_abort = 0; s1_cin = 0; s1_in_valid = 0; s1_out_ready = 1;
        s1_in_a = 0; s1_in_b = 0;

        tab[0] = '{cin: 1'b0,
                   a: '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000},
                   b: '{16'h0001, 16'h0000, 16'h0000, 16'h0000},
                   s: '{16'h0000, 16'h0000, 16'h0001, 16'h0000}, cout: 1'b0};
        tab[1] = '{cin: 1'b1,
                   a: '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                   b: '{16'h0000, 16'h0000, 16'h0000, 16'h0000},
                   s: '{16'h0000, 16'h0000, 16'h0000, 16'h0000}, cout: 1'b1};
        tab[2] = '{cin: 1'b0,
                   a: '{16'h1234, 16'h8000, 16'h0001, 16'hFFFF},
                   b: '{16'h1111, 16'h8000, 16'h0002, 16'h0000},
                   s: '{16'h2345, 16'h0000, 16'h0004, 16'hFFFF}, cout: 1'b0};
        tab[3] = '{cin: 1'b0,
                   a: '{16'hAAAA, 16'h5555, 16'h1234, 16'hFFFF},
                   b: '{16'h5555, 16'hAAAA, 16'h4321, 16'h0001},
                   s: '{16'hFFFF, 16'hFFFF, 16'h5555, 16'h0000}, cout: 1'b1};

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_cout", cout, 0);
        chk("rst1_busy", s1_busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // In IDLE, in_valid is ignored
        in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222;
        #1;
        chk("idle_in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("idle_no_output", out_valid, 0);
        in_valid = 1'b0;

        // Table-driven operations (tab[1] then tab[2] also covers cout clear)
        for (int i = 0; i < 4; i++) run_op(i, 0, 1'b0);

        // Backpressure on the first word
        run_op(2, 3, 1'b0);

        // start while busy is ignored
        run_op(3, 0, 1'b1);

        // Abort after two accepted words of a carry-generating operation
        cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0000; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_pre_valid", out_valid, 1);
        abort = 1'b1; out_ready = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 0);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_last", out_last, 0);
        chk("abort_no_done", done, 0);
        chk("abort_out_sum_kept", out_sum, 16'h0000);
        @(posedge clk); #1;
        chk("abort_no_done_later", done, 0);
        sb_q.delete();
        run_op(0, 0, 1'b0);

        // start && abort in IDLE stays idle
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        #1;
        chk("start_abort_in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("start_abort_busy2", busy, 0);

        // Asynchronous reset mid-run with out_valid high
        cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h1111; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("prerst_out_valid", out_valid, 1);
        chk("prerst_out_sum", out_sum, 16'h2345);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_sum", out_sum, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_done", done, 0);
        chk("arst_in_ready", in_ready, 0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("arst_no_done", done, 0);
        sb_q.delete();
        run_op(1, 0, 1'b0);

        // NWORDS=1: 7FFF + 0001 and FFFF + 0001
        for (int k = 0; k < 2; k++) begin
            s1_cin = 1'b0; s1_start = 1'b1;
            @(posedge clk); #1;
            s1_start = 1'b0;
            s1_in_valid = 1'b1;
            s1_in_a = (k == 0) ? 16'h7FFF : 16'hFFFF;
            s1_in_b = 16'h0001;
            s1_out_ready = 1'b1;
            #1;
            chk("n1_in_ready", s1_in_ready, 1);
            @(posedge clk); #1;
            s1_in_valid = 1'b0;
            chk("n1_out_valid", s1_out_valid, 1);
            chk("n1_out_sum", s1_out_sum, (k == 0) ? 16'h8000 : 16'h0000);
            chk("n1_out_last", s1_out_last, 1);
            chk("n1_flush_in_ready", s1_in_ready, 0);
            chk("n1_busy", s1_busy, 1);
            @(posedge clk); #1;
            chk("n1_done", s1_done, 1);
            chk("n1_cout", s1_cout, (k == 0) ? 0 : 1);
            chk("n1_idle", s1_busy, 0);
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
